prod_accumulator: RTL and testbench
===================================

Name: prod_accumulator

Overview:
- Sequential stage directly downstream of the 4-bit array multiplier: consumes its 8-bit product stream and sums N_TERMS consecutive products into one result (4x4 dot-product / MAC output stage).
- Valid/ready handshake on both sides.
- Saturating accumulator with a sticky overflow flag.
- Result register holds the sum until the consumer takes it.

Parameters:
- N_TERMS, 4, products per result; legal range 1..255.
- ACC_W, 12, accumulator/result width in bits; legal range 8..16.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- clear  input  1  synchronous abort: discard partial sum and any held result.
- in_valid  input  1  prod is valid this cycle.
- in_ready  output  1  block accepts prod this cycle.
- prod  input  8  unsigned product from multiplier.
- out_valid  output  1  acc_out/ovf hold a completed result.
- out_ready  input  1  consumer takes the result this cycle.
- acc_out  output  ACC_W  completed sum, unsigned.
- ovf  output  1  result saturated (valid with out_valid).
- term_cnt  output  8  products accepted into the current sum.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, immediate): state=ACC, acc=0, term_cnt=0, ovf=0, out_valid=0, acc_out=0. A partial sum in progress is lost.
- Transfers: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- in_ready = (state==ACC) | out_ready. This is a combinational path from out_ready; no other combinational input-to-output paths.
- FSM states: ACC, HOLD.
- ACC, on input transfer:
  - acc <= sat(acc + prod); term_cnt++.
  - If the accepted product is the N_TERMS-th: go HOLD; acc_out <= sat sum; out_valid=1 from the next cycle. Latency is 1 cycle from the last accepted product.
- HOLD:
  - out_valid=1; acc_out and ovf stable until output transfer.
  - Output transfer with no input transfer: acc=0, term_cnt=0, ovf=0, out_valid=0 next cycle; go ACC.
  - Output transfer and input transfer in the same cycle: the new sum starts with prod (acc=prod, term_cnt=1, ovf=0).
    - If N_TERMS==1, stay in HOLD with the new result; out_valid stays 1. Full throughput, no bubble.
- Saturation:
  - sum computed ACC_W+1 bits wide.
  - If it exceeds 2^ACC_W-1, acc clamps to 2^ACC_W-1 and ovf is set.
  - ovf is sticky until the result is consumed, clear, or reset; later products leave acc at max.
- clear=1: next cycle state=ACC, acc=0, term_cnt=0, ovf=0, out_valid=0. clear has priority over both transfers in the same cycle; a product offered that cycle is not counted.
- in_valid low in ACC: state, acc and term_cnt hold.
- prod with in_valid=0 is ignored; X on prod is harmless.
- acc_out holds its last value while out_valid=0. Consumers must not sample it then.

Test Plan:
- N_TERMS=4, ACC_W=12, out_ready=1. Feed 0x30,0x1C,0x1C,0x64 on consecutive cycles -> out_valid=1 one cycle after the 4th, acc_out=0x0CC, ovf=0; term_cnt sequence 1,2,3,4.
- Backpressure: same stimulus, out_ready=0 for 5 cycles after result -> acc_out=0x0CC held, in_ready=0, in_valid products not taken. Raise out_ready together with in_valid, prod=0x3A -> new sum starts, term_cnt=1, acc=0x03A.
- Saturation, ACC_W=8, N_TERMS=4: 0xE1,0x64,0x01,0x00 -> acc_out=0xFF, ovf=1. The next result from 0x01 x4 -> acc_out=0x04, ovf=0.
- N_TERMS=1, out_ready=1, continuous in_valid with 0x10,0x2F,0x64 -> out_valid stays 1 with acc_out 0x10,0x2F,0x64 on successive cycles, no bubble.
- clear after 2 of 4 products, in_valid=1 on the clear cycle with 0x55 -> term_cnt=0, 0x55 dropped. The next 4 products 0x01,0x02,0x03,0x04 -> acc_out=0x00A.
- Assert rst_n=0 asynchronously mid-sum and mid-HOLD -> all outputs 0 immediately, no clock edge needed. After release, the first 4 products accumulate from 0.

Source files
------------

// File: rtl/prod_accumulator.sv
// ---------------------------------------------------------------------------
// prod_accumulator
//   Output stage of the 4x4 array multiplier: sums N_TERMS consecutive 8-bit
//   unsigned products into one saturating ACC_W-bit result and holds that
//   result until the consumer takes it.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   clear      synchronous abort of partial sum and held result
//   in_valid   prod is valid this cycle
//   in_ready   block accepts prod this cycle (combinational from out_ready)
//   prod       unsigned product from multiplier
//   out_valid  acc_out/ovf hold a completed result
//   out_ready  consumer takes the result this cycle
//   acc_out    completed sum, unsigned
//   ovf        result saturated (qualified by out_valid)
//   term_cnt   products accepted into the current sum
// ---------------------------------------------------------------------------
module prod_accumulator #(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       prod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             ovf,
    output logic [7:0]       term_cnt
);

    typedef enum logic {ACC, HOLD} state_t;

    localparam logic [7:0] LAST = 8'(N_TERMS);

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [ACC_W-1:0] acc_out_nxt;
    logic             ovf_nxt;
    logic [7:0]       cnt_nxt;
    logic             in_xfer, out_xfer;
    logic [ACC_W:0]   sum_run;    // {overflow, value} of acc + prod
    logic [ACC_W:0]   sum_first;  // {overflow, value} of a fresh sum
    logic [7:0]       cnt_inc;

    // Returns {saturated, clamped value}; the sum is formed one bit wider
    // than the accumulator so the carry out marks overflow.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [7:0]       p);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {{(ACC_W+1-8){1'b0}}, p};
        if (s[ACC_W])
            sat_add = {1'b1, {ACC_W{1'b1}}};
        else
            sat_add = {1'b0, s[ACC_W-1:0]};
    endfunction

    assign out_valid = (state == HOLD);
    assign in_ready  = (state == ACC) | out_ready;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;
    assign sum_run   = sat_add(acc, prod);
    assign sum_first = sat_add('0, prod);
    assign cnt_inc   = term_cnt + 8'd1;

    always_comb begin
        state_nxt   = state;
        acc_nxt     = acc;
        acc_out_nxt = acc_out;
        ovf_nxt     = ovf;
        cnt_nxt     = term_cnt;
        if (clear) begin
            // clear wins over both transfers; acc_out keeps its stale value
            state_nxt = ACC;
            acc_nxt   = '0;
            ovf_nxt   = 1'b0;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ACC: begin
                    if (in_xfer) begin
                        acc_nxt = sum_run[ACC_W-1:0];
                        ovf_nxt = ovf | sum_run[ACC_W];
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == LAST) begin
                            state_nxt   = HOLD;
                            acc_out_nxt = sum_run[ACC_W-1:0];
                        end
                    end
                end
                HOLD: begin
                    if (out_xfer) begin
                        if (in_xfer) begin
                            // Result leaves while the next sum's first term
                            // arrives: no bubble between sums.
                            acc_nxt = sum_first[ACC_W-1:0];
                            ovf_nxt = sum_first[ACC_W];
                            cnt_nxt = 8'd1;
                            if (LAST == 8'd1)
                                acc_out_nxt = sum_first[ACC_W-1:0];
                            else
                                state_nxt = ACC;
                        end else begin
                            state_nxt = ACC;
                            acc_nxt   = '0;
                            ovf_nxt   = 1'b0;
                            cnt_nxt   = '0;
                        end
                    end
                end
                default: state_nxt = ACC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ACC;
            acc      <= '0;
            acc_out  <= '0;
            ovf      <= 1'b0;
            term_cnt <= '0;
        end else begin
            state    <= state_nxt;
            acc      <= acc_nxt;
            acc_out  <= acc_out_nxt;
            ovf      <= ovf_nxt;
            term_cnt <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_prod_accumulator.sv
module tb_prod_accumulator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] prod = 8'h00;

    // three configurations share the stimulus; sel picks the one observed
    logic        ir4, ov4, of4;  logic [11:0] ao4; logic [7:0] tc4;
    logic        ir8, ov8, of8;  logic [7:0]  ao8; logic [7:0] tc8;
    logic        ir1, ov1, of1;  logic [11:0] ao1; logic [7:0] tc1;

    logic [1:0]  sel = 2'd0;
    logic        m_in_ready, m_out_valid, m_ovf;
    logic [11:0] m_acc_out;
    logic [7:0]  m_term_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct { logic [11:0] v; logic o; } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;

    prod_accumulator #(.N_TERMS(4), .ACC_W(12)) u4 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .in_ready(ir4), .prod(prod), .out_valid(ov4), .out_ready(out_ready),
        .acc_out(ao4), .ovf(of4), .term_cnt(tc4));
    prod_accumulator #(.N_TERMS(4), .ACC_W(8)) u8 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .in_ready(ir8), .prod(prod), .out_valid(ov8), .out_ready(out_ready),
        .acc_out(ao8), .ovf(of8), .term_cnt(tc8));
    prod_accumulator #(.N_TERMS(1), .ACC_W(12)) u1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .in_ready(ir1), .prod(prod), .out_valid(ov1), .out_ready(out_ready),
        .acc_out(ao1), .ovf(of1), .term_cnt(tc1));

    always_comb begin
        m_in_ready = ir4; m_out_valid = ov4; m_ovf = of4; m_acc_out = ao4; m_term_cnt = tc4;
        case (sel)
            2'd1: begin
                m_in_ready = ir8; m_out_valid = ov8; m_ovf = of8;
                m_acc_out = {4'h0, ao8}; m_term_cnt = tc8;
            end
            2'd2: begin
                m_in_ready = ir1; m_out_valid = ov1; m_ovf = of1;
                m_acc_out = ao1; m_term_cnt = tc1;
            end
            default: ;
        endcase
    end

    // Scoreboard: every output transfer of the observed instance pops one entry.
    always @(negedge clk) begin
        if (rst_n && !clear && m_out_valid && out_ready) begin
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected got=%0h/%0b exp=none", m_acc_out, m_ovf);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (m_acc_out !== e.v || m_ovf !== e.o) begin
                    bad++;
                    $display("FAIL sb_result got=%0h/%0b exp=%0h/%0b", m_acc_out, m_ovf, e.v, e.o);
                end
            end
        end
    end

    task automatic push(input logic [11:0] v, input logic o);
        exp_t e;
        e.v = v; e.o = o;
        sbq.push_back(e);
    endtask

    task automatic do_reset(input logic [1:0] s);
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        sel = s;
        sbq.delete();
        #2;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // one accepted product per cycle; ends 1 time unit after the edge
    task automatic feed(input logic [7:0] p);
        in_valid = 1'b1; prod = p;
        @(posedge clk); #1;
        in_valid = 1'b0; prod = 8'hxx;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
        #1;
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL %s_timeout got=%0d pending exp=0", name, sbq.size());
        end
    endtask

    task automatic check_zero(input string name);
        total++;
        if (m_out_valid !== 1'b0 || m_acc_out !== 12'h0 || m_ovf !== 1'b0 || m_term_cnt !== 8'h0) begin
            bad++;
            $display("FAIL %s got=v%0b a%0h o%0b c%0d exp=all zero", name, m_out_valid, m_acc_out, m_ovf, m_term_cnt);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        sel = 2'd0; #1;
        check_zero("reset_u4");
        total++;
        if (m_in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready got=%0b exp=1", m_in_ready);
        end
        sel = 2'd1; #1; check_zero("reset_u8");
        sel = 2'd2; #1; check_zero("reset_u1");
    endtask

    task automatic test_basic;
        logic [7:0] p [4] = '{8'h30, 8'h1C, 8'h1C, 8'h64};
        do_reset(2'd0);
        push(12'h0CC, 1'b0);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; prod = p[i];
            @(posedge clk); #1;
            total++;
            if (m_term_cnt !== 8'(i + 1)) begin
                bad++; $display("FAIL basic_cnt got=%0d exp=%0d", m_term_cnt, i + 1);
            end
        end
        in_valid = 1'b0;
        total++;
        if (m_out_valid !== 1'b1) begin
            bad++; $display("FAIL basic_latency got=%0b exp=1", m_out_valid);
        end
        @(posedge clk); #1;
        total++;
        if (m_out_valid !== 1'b0 || m_term_cnt !== 8'd0) begin
            bad++; $display("FAIL basic_after got=v%0b c%0d exp=v0 c0", m_out_valid, m_term_cnt);
        end
        drain("basic");
    endtask

    task automatic test_back_to_back;
        do_reset(2'd0);
        push(12'h0CC, 1'b0);
        feed(8'h30); feed(8'h1C); feed(8'h1C);
        out_ready = 1'b0;
        feed(8'h64);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; prod = 8'h77;
            #1;
            total++;
            if (m_in_ready !== 1'b0 || m_out_valid !== 1'b1 || m_acc_out !== 12'h0CC || m_term_cnt !== 8'd4) begin
                bad++;
                $display("FAIL bp_hold got=r%0b v%0b a%0h c%0d exp=r0 v1 a0cc c4",
                         m_in_ready, m_out_valid, m_acc_out, m_term_cnt);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1; prod = 8'h3A;
        #1;
        total++;
        if (m_in_ready !== 1'b1) begin
            bad++; $display("FAIL bp_release_ready got=%0b exp=1", m_in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++;
        if (m_term_cnt !== 8'd1 || m_out_valid !== 1'b0) begin
            bad++; $display("FAIL bp_restart got=c%0d v%0b exp=c1 v0", m_term_cnt, m_out_valid);
        end
        push(12'h03D, 1'b0);
        feed(8'h01); feed(8'h01); feed(8'h01);
        drain("bp");
    endtask

    task automatic test_saturation;
        do_reset(2'd1);
        push(12'h0FF, 1'b1);
        push(12'h004, 1'b0);
        feed(8'hE1); feed(8'h64);
        total++;
        if (m_ovf !== 1'b1 || m_term_cnt !== 8'd2) begin
            bad++; $display("FAIL sat_sticky got=o%0b c%0d exp=o1 c2", m_ovf, m_term_cnt);
        end
        feed(8'h01); feed(8'h00);
        for (int i = 0; i < 4; i++) feed(8'h01);
        drain("sat");
    endtask

    task automatic test_single;
        logic [7:0] p [3] = '{8'h10, 8'h2F, 8'h64};
        do_reset(2'd2);
        for (int i = 0; i < 3; i++) push({4'h0, p[i]}, 1'b0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; prod = p[i];
            @(posedge clk); #1;
            total++;
            if (m_out_valid !== 1'b1 || m_acc_out !== {4'h0, p[i]}) begin
                bad++; $display("FAIL single_stream got=v%0b a%0h exp=v1 a%0h", m_out_valid, m_acc_out, p[i]);
            end
        end
        in_valid = 1'b0;
        drain("single");
    endtask

    task automatic test_clear;
        do_reset(2'd0);
        feed(8'h11); feed(8'h22);
        clear = 1'b1; in_valid = 1'b1; prod = 8'h55;
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        total++;
        if (m_term_cnt !== 8'd0 || m_out_valid !== 1'b0 || m_ovf !== 1'b0) begin
            bad++; $display("FAIL clear_state got=c%0d v%0b o%0b exp=c0 v0 o0", m_term_cnt, m_out_valid, m_ovf);
        end
        push(12'h00A, 1'b0);
        feed(8'h01); feed(8'h02); feed(8'h03); feed(8'h04);
        drain("clear");
    endtask

    task automatic test_async_reset;
        do_reset(2'd0);
        feed(8'h20); feed(8'h20);
        #2 rst_n = 1'b0;
        #1 check_zero("areset_midsum");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) feed(8'h10);
        total++;
        if (m_out_valid !== 1'b1 || m_acc_out !== 12'h040) begin
            bad++; $display("FAIL areset_prehold got=v%0b a%0h exp=v1 a40", m_out_valid, m_acc_out);
        end
        #2 rst_n = 1'b0;
        #1 check_zero("areset_midhold");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        push(12'h00A, 1'b0);
        feed(8'h01); feed(8'h02); feed(8'h03); feed(8'h04);
        drain("areset");
    endtask

    initial begin
        test_reset;
        test_basic;
        test_back_to_back;
        test_saturation;
        test_single;
        test_clear;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
